// File: rtl/regfile_fwd_sb_if.sv
// Bundle of decode-stage register file signals: read ports, bypass stages, writeback,
// long-latency issue tracking and debug/observation outputs.
interface regfile_fwd_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 3,
    parameter int NFWD = 3
) ();
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NFWD-1:0]      fwd_vld;
    logic [NFWD*AW-1:0]   fwd_idx;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 wb_en;
    logic [AW-1:0]        wb_idx;
    logic [XLEN-1:0]      wb_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_idx;
    logic                 flush;
    logic [AW-1:0]        dbg_idx;
    logic [XLEN-1:0]      dbg_data;
    logic [NREG-1:0]      pend_vec;

    modport master (
        output rd_addr, fwd_vld, fwd_idx, fwd_data, wb_en, wb_idx, wb_data,
               iss_en, iss_idx, flush, dbg_idx,
        input  rd_data, rd_busy, dbg_data, pend_vec
    );

    modport slave (
        input  rd_addr, fwd_vld, fwd_idx, fwd_data, wb_en, wb_idx, wb_data,
               iss_en, iss_idx, flush, dbg_idx,
        output rd_data, rd_busy, dbg_data, pend_vec
    );
endinterface

// File: rtl/regfile_fwd_sb.sv
// Decode-stage integer register file with priority bypass from in-flight stages,
// same-cycle writeback bypass and a pending-write scoreboard for long-latency ops.
module regfile_fwd_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 3,
    parameter int NFWD = 3
) (
    input  logic               clk,
    input  logic               cpurst,
    regfile_fwd_sb_if.slave    bus
);
    localparam int AW = $clog2(NREG);
    // The debug port is simply one more instance of the shared read mux.
    localparam int NP = NRD + 1;

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] pend_r;

    // Architectural array: x0 is never written so it stays zero.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
        end else if (bus.wb_en && (bus.wb_idx != {AW{1'b0}})) begin
            regs_r[bus.wb_idx] <= bus.wb_data;
        end
    end

    // Scoreboard: flush dominates; a same-cycle issue overrides the writeback clear.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            pend_r <= {NREG{1'b0}};
        end else if (bus.flush) begin
            pend_r <= {NREG{1'b0}};
        end else begin
            if (bus.wb_en && (bus.wb_idx != {AW{1'b0}})) begin
                pend_r[bus.wb_idx] <= 1'b0;
            end
            if (bus.iss_en && (bus.iss_idx != {AW{1'b0}})) begin
                pend_r[bus.iss_idx] <= 1'b1;
            end
        end
    end

    assign bus.pend_vec = pend_r;

    for (genvar p = 0; p < NP; p++) begin : g_port
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] mux_s;
        logic [XLEN-1:0] fwd_val_s;
        logic            fwd_hit_s;
        logic            match_s;

        if (p < NRD) begin : g_rd
            assign addr_s = bus.rd_addr[p*AW +: AW];
            assign bus.rd_data[p*XLEN +: XLEN] = mux_s;
            // A same-cycle writeback releases the stall; forward stages never do.
            assign bus.rd_busy[p] = (addr_s != {AW{1'b0}}) && pend_r[addr_s] &&
                                    !(bus.wb_en && (bus.wb_idx == addr_s));
        end else begin : g_dbg
            assign addr_s = bus.dbg_idx;
            assign bus.dbg_data = mux_s;
        end

        // Scan oldest to youngest so the lowest matching stage is the one that sticks.
        always_comb begin
            fwd_hit_s = 1'b0;
            fwd_val_s = {XLEN{1'b0}};
            match_s   = 1'b0;
            for (int k = NFWD - 1; k >= 0; k--) begin
                match_s   = bus.fwd_vld[k] && (bus.fwd_idx[k*AW +: AW] == addr_s);
                fwd_val_s = match_s ? bus.fwd_data[k*XLEN +: XLEN] : fwd_val_s;
                fwd_hit_s = fwd_hit_s | match_s;
            end
        end

        // Final priority: x0, bypass stages, writeback, array.
        always_comb begin
            mux_s = {XLEN{1'b0}};
            if (addr_s == {AW{1'b0}}) begin
                mux_s = {XLEN{1'b0}};
            end else if (fwd_hit_s) begin
                mux_s = fwd_val_s;
            end else if (bus.wb_en && (bus.wb_idx == addr_s)) begin
                mux_s = bus.wb_data;
            end else begin
                mux_s = regs_r[addr_s];
            end
        end
    end
endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Randomised and directed bench for regfile_fwd_sb against an array/bitmask reference model.
module tb_regfile_fwd_sb;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NFWD = 2;
    localparam int AW   = $clog2(NREG);

    logic clk;
    logic cpurst;
    int   n_checks;
    int   n_fail;

    logic [XLEN-1:0] ref_regs [NREG];
    logic [NREG-1:0] ref_pend;

    regfile_fwd_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD)) bus ();

    regfile_fwd_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD)) dut (
        .clk    (clk),
        .cpurst (cpurst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        for (int k = 0; k < NFWD; k++) begin
            if (bus.fwd_vld[k] && bus.fwd_idx[k*AW +: AW] == a) return bus.fwd_data[k*XLEN +: XLEN];
        end
        if (bus.wb_en && bus.wb_idx == a) return bus.wb_data;
        return ref_regs[a];
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] a);
        return (a != 0) && ref_pend[a] && !(bus.wb_en && bus.wb_idx == a);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) ref_regs[r] = '0;
        ref_pend = '0;
    endtask

    task automatic clear_inputs();
        bus.rd_addr = '0; bus.fwd_vld = '0; bus.fwd_idx = '0; bus.fwd_data = '0;
        bus.wb_en = 1'b0; bus.wb_idx = '0; bus.wb_data = '0;
        bus.iss_en = 1'b0; bus.iss_idx = '0; bus.flush = 1'b0; bus.dbg_idx = '0;
    endtask

    // Let combinational outputs settle, then compare every read port and the debug port.
    task automatic check_comb(input string tag);
        #1;
        for (int i = 0; i < NRD; i++) begin
            check_eq({tag, "_data"}, bus.rd_data[i*XLEN +: XLEN], model_read(bus.rd_addr[i*AW +: AW]));
            check_eq({tag, "_busy"}, {63'd0, bus.rd_busy[i]}, {63'd0, model_busy(bus.rd_addr[i*AW +: AW])});
        end
        check_eq({tag, "_dbg"}, bus.dbg_data, model_read(bus.dbg_idx));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!cpurst) begin
            if (bus.flush) begin
                ref_pend = '0;
            end else begin
                if (bus.wb_en && bus.wb_idx != 0) ref_pend[bus.wb_idx] = 1'b0;
                if (bus.iss_en && bus.iss_idx != 0) ref_pend[bus.iss_idx] = 1'b1;
            end
            if (bus.wb_en && bus.wb_idx != 0) ref_regs[bus.wb_idx] = bus.wb_data;
        end
        #1;
        check_eq("pend_vec", {32'd0, bus.pend_vec}, {32'd0, ref_pend});
    endtask

    function automatic logic [AW-1:0] rnd_idx();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cpurst   = 1'b1;
        clear_inputs();
        model_reset();
        #3;
        check_comb("reset");
        check_eq("reset_pend", {32'd0, bus.pend_vec}, 64'd0);
        #9;
        cpurst = 1'b0;

        // Mid-cycle asynchronous reset with x5=7 and x5 pending.
        bus.wb_en = 1'b1; bus.wb_idx = 5'd5; bus.wb_data = 64'd7;
        check_comb("x5_wr"); tick();
        clear_inputs(); bus.iss_en = 1'b1; bus.iss_idx = 5'd5;
        tick();
        clear_inputs(); bus.rd_addr[0 +: AW] = 5'd5;
        check_comb("x5_pre");
        check_eq("x5_pre_busy", {63'd0, bus.rd_busy[0]}, 64'd1);
        #2 cpurst = 1'b1;
        #1 model_reset();
        check_eq("rst_mid_pend", {32'd0, bus.pend_vec}, 64'd0);
        check_eq("rst_mid_x5", bus.rd_data[0 +: XLEN], 64'd0);
        check_eq("rst_mid_busy", {63'd0, bus.rd_busy[0]}, 64'd0);
        bus.wb_en = 1'b1; bus.wb_idx = 5'd5; bus.wb_data = 64'd9;
        bus.iss_en = 1'b1; bus.iss_idx = 5'd5;
        tick();
        #2 cpurst = 1'b0;
        clear_inputs(); bus.rd_addr[0 +: AW] = 5'd5;
        check_comb("post_rst");
        check_eq("post_rst_x5", bus.rd_data[0 +: XLEN], 64'd0);

        // Bypass priority on x15.
        clear_inputs(); bus.wb_en = 1'b1; bus.wb_idx = 5'd15; bus.wb_data = 64'h1234;
        tick();
        clear_inputs();
        bus.rd_addr[0 +: AW] = 5'd15; bus.dbg_idx = 5'd15;
        bus.fwd_vld = 2'b11; bus.fwd_idx = {5'd15, 5'd15}; bus.fwd_data = {64'hB, 64'hA};
        bus.wb_en = 1'b1; bus.wb_idx = 5'd15; bus.wb_data = 64'hC;
        check_comb("prio_all"); check_eq("prio_fwd0", bus.rd_data[0 +: XLEN], 64'hA);
        check_eq("prio_dbg", bus.dbg_data, 64'hA);
        bus.fwd_vld = 2'b10;
        check_comb("prio_f1"); check_eq("prio_fwd1", bus.rd_data[0 +: XLEN], 64'hB);
        bus.fwd_vld = 2'b00;
        check_comb("prio_wb"); check_eq("prio_wbv", bus.rd_data[0 +: XLEN], 64'hC);
        bus.wb_en = 1'b0;
        check_comb("prio_arr"); check_eq("prio_array", bus.rd_data[0 +: XLEN], 64'h1234);
        tick();

        // x0 is immune to writes, bypass and issue.
        clear_inputs();
        bus.wb_en = 1'b1; bus.wb_idx = '0; bus.wb_data = 64'hFFFF_FFFF;
        bus.fwd_vld = 2'b11; bus.fwd_data = {64'h77, 64'h66};
        bus.iss_en = 1'b1;
        check_comb("x0");
        for (int i = 0; i < NRD; i++) check_eq("x0_data", bus.rd_data[i*XLEN +: XLEN], 64'd0);
        check_eq("x0_busy", {60'd0, bus.rd_busy}, 64'd0);
        tick();
        check_eq("x0_pend", {63'd0, bus.pend_vec[0]}, 64'd0);
        clear_inputs();
        check_comb("x0_after");

        // Scoreboard set / same-cycle release on x7.
        bus.iss_en = 1'b1; bus.iss_idx = 5'd7;
        tick();
        clear_inputs(); bus.rd_addr[0 +: AW] = 5'd7;
        check_comb("sb_busy"); check_eq("sb_busy1", {63'd0, bus.rd_busy[0]}, 64'd1);
        bus.wb_en = 1'b1; bus.wb_idx = 5'd7; bus.wb_data = 64'h55;
        check_comb("sb_rel"); check_eq("sb_rel_busy", {63'd0, bus.rd_busy[0]}, 64'd0);
        check_eq("sb_rel_data", bus.rd_data[0 +: XLEN], 64'h55);
        tick();
        check_eq("sb_pend7", {63'd0, bus.pend_vec[7]}, 64'd0);

        // Issue/writeback collision on x9, then flush overriding a new issue.
        clear_inputs();
        bus.iss_en = 1'b1; bus.iss_idx = 5'd9;
        bus.wb_en = 1'b1; bus.wb_idx = 5'd9; bus.wb_data = 64'h99;
        tick();
        check_eq("coll_pend9", {63'd0, bus.pend_vec[9]}, 64'd1);
        clear_inputs(); bus.flush = 1'b1; bus.iss_en = 1'b1; bus.iss_idx = 5'd3;
        tick();
        check_eq("flush_pend", {32'd0, bus.pend_vec}, 64'd0);

        // Random traffic against the reference model.
        for (int c = 0; c < 10000; c++) begin
            clear_inputs();
            for (int i = 0; i < NRD; i++) bus.rd_addr[i*AW +: AW] = rnd_idx();
            for (int k = 0; k < NFWD; k++) begin
                bus.fwd_vld[k] = $urandom_range(0, 1) == 1;
                bus.fwd_idx[k*AW +: AW] = rnd_idx();
                bus.fwd_data[k*XLEN +: XLEN] = {$urandom, $urandom};
            end
            bus.wb_en   = $urandom_range(0, 1) == 1;
            bus.wb_idx  = rnd_idx();
            bus.wb_data = {$urandom, $urandom};
            bus.iss_en  = $urandom_range(0, 3) == 0;
            bus.iss_idx = rnd_idx();
            bus.flush   = $urandom_range(0, 31) == 0;
            bus.dbg_idx = ($urandom_range(0, 1) == 1) ? bus.rd_addr[0 +: AW] : rnd_idx();
            check_comb("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
